// File: rtl/round_constant_sequencer.sv
// round_constant_sequencer: multicycle companion to the single-cycle
// round-constant instruction. It adds one round constant per enabled clock
// to a 7-bit state value, walking the round index with wrap-around, and
// returns the final value with a one-cycle done pulse.
module round_constant_sequencer #(
  parameter int DATA_W     = 7,
  parameter int NUM_ROUNDS = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  state_t              state;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   result_q;
  logic [DATA_W-1:0]   round_const;
  logic [3:0]          idx;
  logic [3:0]          cnt;
  logic                unused_bits;

  // Operand bits above the fields we use are deliberately ignored.
  assign unused_bits = ^{dataa[31:DATA_W], datab[31:8]};

  // Final value is zero-extended onto the 32-bit result bus.
  assign result = {{(32 - DATA_W){1'b0}}, result_q};

  // Round-constant table; indices past the last entry reuse the last constant.
  always_comb begin
    round_const = DATA_W'(7'h22);
    case (idx)
      4'd0:    round_const = DATA_W'(7'h5A);
      4'd1:    round_const = DATA_W'(7'h34);
      4'd2:    round_const = DATA_W'(7'h73);
      4'd3:    round_const = DATA_W'(7'h66);
      4'd4:    round_const = DATA_W'(7'h57);
      4'd5:    round_const = DATA_W'(7'h35);
      4'd6:    round_const = DATA_W'(7'h71);
      4'd7:    round_const = DATA_W'(7'h62);
      4'd8:    round_const = DATA_W'(7'h5F);
      4'd9:    round_const = DATA_W'(7'h25);
      4'd10:   round_const = DATA_W'(7'h51);
      default: round_const = DATA_W'(7'h22);
    endcase
  end

  // Controller: latch operands on start, accumulate one constant per enabled
  // clock while counting down, then publish the result with a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      idx      <= '0;
      cnt      <= '0;
      result_q <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else if (clk_en) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= dataa[DATA_W-1:0];
            idx   <= datab[3:0];
            cnt   <= datab[7:4];
            busy  <= 1'b1;
            state <= (datab[7:4] == 4'd0) ? FINISH : RUN;
          end
        end
        RUN: begin
          acc <= acc + round_const;
          idx <= (idx >= LAST_IDX) ? 4'd0 : idx + 4'd1;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          result_q <= acc;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_constant_sequencer.sv
// Testbench for round_constant_sequencer: directed cases plus randomized
// operations (with random stalls and spurious starts) checked against a
// simple arithmetic reference model.
module tb_round_constant_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;
  logic        busy;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [31:0] lastResult = '0;

  logic [6:0]  constTable [0:11] = '{7'h5A, 7'h34, 7'h73, 7'h66, 7'h57, 7'h35,
                                     7'h71, 7'h62, 7'h5F, 7'h25, 7'h51, 7'h22};

  round_constant_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .datab  (datab),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Reference: n additions of the table constant, index wrapping after 11.
  function automatic logic [31:0] modelResult(input logic [31:0] a, input logic [31:0] b);
    int acc;
    int idx;
    int n;
    acc = int'(a[6:0]);
    idx = int'(b[3:0]);
    n   = int'(b[7:4]);
    for (int k = 0; k < n; k++) begin
      acc = (acc + int'((idx < 12) ? constTable[idx] : 7'h22)) % 128;
      idx = (idx >= 11) ? 0 : idx + 1;
    end
    return 32'(acc);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  // One full operation: start edge, run with optional stalls/noise, done,
  // then confirm done holds through a stall and clears on the next edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input int stallAt, input bit noisy);
    int          n;
    int          e;
    int          iter;
    int          stallLeft;
    bit          stalled;
    logic [31:0] expected;
    n         = int'(b[7:4]);
    expected  = modelResult(a, b);
    e         = 0;
    iter      = 0;
    stallLeft = 0;
    stalled   = 1'b0;
    dataa     = a;
    datab     = b;
    start     = 1'b1;
    clk_en    = 1'b1;
    stepEdge();
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("done_after_start", 32'(done), 32'd0);
    while (e < n + 1 && iter < 500) begin
      iter++;
      if (!stalled && e == stallAt) begin
        stallLeft = 3;
        stalled   = 1'b1;
      end
      if (stallLeft > 0) begin
        clk_en = 1'b0;
        stallLeft--;
      end else begin
        clk_en = noisy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        dataa = $urandom;
        datab = $urandom;
      end
      stepEdge();
      if (clk_en) e++;
      if (e == n + 1) begin
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("result", result, expected);
        checkOutput("busy_end", 32'(busy), 32'd0);
      end else begin
        checkOutput("done_early", 32'(done), 32'd0);
        checkOutput("busy_run", 32'(busy), 32'd1);
        checkOutput("result_hold", result, lastResult);
      end
    end
    start = 1'b0;
    if (e < n + 1) checkOutput("timeout", 32'(e), 32'(n + 1));
    lastResult = expected;
    clk_en = 1'b0;
    stepEdge();
    checkOutput("done_hold_stall", 32'(done), 32'd1);
    clk_en = 1'b1;
    stepEdge();
    checkOutput("done_clear", 32'(done), 32'd0);
    checkOutput("result_keep", result, lastResult);
    checkOutput("busy_idle", 32'(busy), 32'd0);
  endtask

  // Main sequence: reset, directed cases, reset abort, randomized runs.
  initial begin
    reset  = 1'b1;
    clk_en = 1'b0;
    start  = 1'b0;
    dataa  = '0;
    datab  = '0;
    #12;
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    stepEdge();
    reset  = 1'b0;
    clk_en = 1'b1;
    stepEdge();

    applyStimulus(32'h00, 32'h10, -1, 1'b0);
    checkOutput("single_round", result, 32'h5A);
    applyStimulus(32'h10, 32'h30, -1, 1'b0);
    checkOutput("three_rounds", result, 32'h11);
    applyStimulus(32'h00, 32'hC0, -1, 1'b0);
    checkOutput("full_schedule", result, 32'h3D);
    applyStimulus(32'h00, 32'h2B, -1, 1'b0);
    checkOutput("index_wrap", result, 32'h7C);
    applyStimulus(32'h00, 32'h1F, -1, 1'b0);
    checkOutput("out_of_range_idx", result, 32'h22);
    applyStimulus(32'hFFFFFFFF, 32'h00, -1, 1'b0);
    checkOutput("zero_count", result, 32'h7F);
    applyStimulus(32'h10, 32'h30, 2, 1'b0);
    checkOutput("stall_mid_run", result, 32'h11);
    applyStimulus(32'h10, 32'h30, 1, 1'b1);
    checkOutput("noisy_run", result, 32'h11);

    dataa  = 32'h00;
    datab  = 32'h50;
    start  = 1'b1;
    clk_en = 1'b1;
    stepEdge();
    start = 1'b0;
    stepEdge();
    stepEdge();
    reset = 1'b1;
    #1;
    checkOutput("abort_result", result, 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    lastResult = '0;
    stepEdge();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      stepEdge();
      checkOutput("no_done_after_abort", 32'(done), 32'd0);
      checkOutput("idle_after_abort", 32'(busy), 32'd0);
    end
    applyStimulus(32'h00, 32'h10, -1, 1'b0);
    checkOutput("after_abort_run", result, 32'h5A);

    for (int i = 0; i < 30; i++) begin
      applyStimulus($urandom, $urandom, int'($urandom_range(0, 6)) - 1,
                    1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
